// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types and default widths for the VGA/CPU memory arbiter.
// Holds the arbiter state enum and the read-return source tag encoding.
package vga_mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH   = 15;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_STARVE_LIMIT = 7;
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic {
    NORMAL    = 1'b0,
    CPU_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_VGA = 1'b0,
    SRC_CPU = 1'b1
  } src_tag_e;

endpackage

// File: rtl/vga_mem_return_pipe.sv
// Read-return routing: carries the source tag alongside each RAM read and
// steers the returning word to exactly one requester, holding it afterwards.
module vga_mem_return_pipe
  import vga_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_issue,
  input  src_tag_e              rd_tag,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata
);

  logic                  s1_vld;
  src_tag_e              s1_tag;
  logic [DATA_WIDTH-1:0] vga_hold;
  logic [DATA_WIDTH-1:0] cpu_hold;

  // s1 lines up with mem_en; rvalid lines up with the RAM's registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s1_tag     <= SRC_VGA;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_hold   <= '0;
      cpu_hold   <= '0;
    end else begin
      s1_vld     <= rd_issue;
      s1_tag     <= rd_tag;
      vga_rvalid <= s1_vld && (s1_tag == SRC_VGA);
      cpu_rvalid <= s1_vld && (s1_tag == SRC_CPU);
      if (vga_rvalid) vga_hold <= mem_rdata;
      if (cpu_rvalid) cpu_hold <= mem_rdata;
    end
  end

  // Bypass so data is visible in the same cycle as rvalid.
  assign vga_rdata = vga_rvalid ? mem_rdata : vga_hold;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Two-requester single-port RAM arbiter: VGA scanout has priority, the CPU is
// forced through after STARVE_LIMIT consecutive VGA wins while it waits.
//   state     | meaning
//   NORMAL    | VGA wins on contention, starve_cnt counts CPU-losing cycles
//   CPU_FORCE | CPU wins on contention; leaves on CPU grant or cpu_req low
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vga_req,
  input  logic [ADDR_WIDTH-1:0]   vga_addr,
  output logic                    vga_ack,
  output logic                    vga_rvalid,
  output logic [DATA_WIDTH-1:0]   vga_rdata,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wmask,
  output logic                    cpu_ack,
  output logic                    cpu_rvalid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_e              state;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [STARVE_CNT_W-1:0] starve_nxt;
  logic                    grant_vga;
  logic                    grant_cpu;
  logic                    rd_issue;
  src_tag_e                rd_tag;

  always_comb begin
    grant_vga = 1'b0;
    grant_cpu = 1'b0;
    if (!reset) begin
      if (vga_req && cpu_req) begin
        grant_cpu = (state == CPU_FORCE);
        grant_vga = (state != CPU_FORCE);
      end else begin
        grant_vga = vga_req;
        grant_cpu = cpu_req;
      end
    end
  end

  assign vga_ack = grant_vga;
  assign cpu_ack = grant_cpu;

  always_comb begin
    starve_nxt = starve_cnt;
    if (grant_cpu || !cpu_req) starve_nxt = '0;
    else if (grant_vga)        starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      case (state)
        NORMAL:    if (starve_nxt == STARVE_CNT_W'(STARVE_LIMIT)) state <= CPU_FORCE;
        CPU_FORCE: if (grant_cpu || !cpu_req) state <= NORMAL;
        default:   state <= NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      mem_en    <= grant_vga || grant_cpu;
      mem_we    <= grant_cpu && cpu_we;
      mem_addr  <= grant_cpu ? cpu_addr : vga_addr;
      mem_wdata <= (grant_cpu && cpu_we) ? cpu_wdata : '0;
      mem_wmask <= (grant_cpu && cpu_we) ? cpu_wmask : '0;
    end
  end

  assign rd_issue = grant_vga || (grant_cpu && !cpu_we);
  assign rd_tag   = grant_cpu ? SRC_CPU : SRC_VGA;

  vga_mem_return_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_return_pipe (
    .clk       (clk),
    .reset     (reset),
    .rd_issue  (rd_issue),
    .rd_tag    (rd_tag),
    .mem_rdata (mem_rdata),
    .vga_rvalid(vga_rvalid),
    .vga_rdata (vga_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata)
  );

endmodule
